// File: rtl/mem_stage.sv
// ---------------------------------------------------------------------------
// mem_stage -- memory-access stage of a 5-stage RV32I pipeline.
//
// Takes the EX/MEM register contents (ALU result, store data, PC+4, control)
// and runs loads/stores over a single-outstanding req/ack data bus. Stores
// get byte-lane steering. Loads are extracted from the returned word and
// sign- or zero-extended. The writeback value is selected and placed in the
// MEM/WB register. The stage stalls upstream while a bus transaction is open.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   valid_MEM_I              EX/MEM holds a live instruction
//   ALU_result_MEM_I [31:0]  effective address or ALU value
//   Rd_data2_MEM_I   [31:0]  store data (rs2)
//   pc_order_MEM_I   [31:0]  PC+4 link value
//   MemRead_MEM_I            load
//   MemWrite_MEM_I           store
//   funct3_MEM_I     [2:0]   access size (B/H/W/BU/HU)
//   wb_sel_MEM_I     [1:0]   00 ALU, 01 load data, 10 PC+4, 11 = ALU
//   RegWrite_MEM_I, rd_MEM_I register-write control
//   mem_req_O/we/addr/wdata/wstrb  data-bus request (held until ack)
//   mem_rdata_I, mem_ack_I   data-bus response (rdata valid with ack)
//   stall_MEM_O              combinational upstream hold
//   *_WB_O                   MEM/WB register outputs
// ---------------------------------------------------------------------------
module mem_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_MEM_I,
  input  logic [31:0] ALU_result_MEM_I,
  input  logic [31:0] Rd_data2_MEM_I,
  input  logic [31:0] pc_order_MEM_I,
  input  logic        MemRead_MEM_I,
  input  logic        MemWrite_MEM_I,
  input  logic [2:0]  funct3_MEM_I,
  input  logic [1:0]  wb_sel_MEM_I,
  input  logic        RegWrite_MEM_I,
  input  logic [4:0]  rd_MEM_I,
  output logic        mem_req_O,
  output logic        mem_we_O,
  output logic [31:0] mem_addr_O,
  output logic [31:0] mem_wdata_O,
  output logic [3:0]  mem_wstrb_O,
  input  logic [31:0] mem_rdata_I,
  input  logic        mem_ack_I,
  output logic        stall_MEM_O,
  output logic        valid_WB_O,
  output logic        RegWrite_WB_O,
  output logic [4:0]  rd_WB_O,
  output logic [31:0] wb_data_WB_O,
  output logic        misalign_WB_O
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  localparam logic [1:0] WB_LOAD = 2'b01;
  localparam logic [1:0] WB_PC4  = 2'b10;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Writeback mux; the reserved encoding 11 falls through to the ALU value.
  function automatic logic [31:0] f_wb_mux(input logic [1:0]  sel,
                                           input logic [31:0] alu,
                                           input logic [31:0] ld,
                                           input logic [31:0] pc4);
    case (sel)
      WB_LOAD: f_wb_mux = ld;
      WB_PC4:  f_wb_mux = pc4;
      default: f_wb_mux = alu;
    endcase
  endfunction

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  state_t      r_state;

  // Bus request registers
  logic        r_mem_req;
  logic        r_mem_we;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_wdata;
  logic [3:0]  r_mem_wstrb;

  // Instruction context captured at issue; WAIT never looks at live inputs
  // because upstream may advance on the ack edge.
  logic [1:0]  r_off;
  logic [2:0]  r_funct3;
  logic [1:0]  r_wb_sel;
  logic [31:0] r_alu;
  logic [31:0] r_pc4;
  logic [4:0]  r_rd;
  logic        r_regwrite;

  // MEM/WB register
  logic        r_valid_wb;
  logic        r_regwrite_wb;
  logic [4:0]  r_rd_wb;
  logic [31:0] r_wb_data;
  logic        r_misalign_wb;

  // -------------------------------------------------------------------------
  // Issue decode (IDLE only)
  // -------------------------------------------------------------------------
  logic        w_is_mem;
  logic        w_misalign;
  logic        w_issue;
  logic        w_misaligned_op;
  logic [1:0]  w_off;

  assign w_off    = ALU_result_MEM_I[1:0];
  assign w_is_mem = MemRead_MEM_I | MemWrite_MEM_I;

  // funct3[1:0]: 00 byte (never misaligned), 01 half, 1x word.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    w_misalign = 1'b0;
    case (funct3_MEM_I[1:0])
      2'b00:   w_misalign = 1'b0;
      2'b01:   w_misalign = w_off[0];
      default: w_misalign = |w_off;
    endcase
  end

  assign w_issue         = (r_state == S_IDLE) && valid_MEM_I && w_is_mem && !w_misalign;
  assign w_misaligned_op = (r_state == S_IDLE) && valid_MEM_I && w_is_mem &&  w_misalign;

  // Depends only on state, issue controls and ack -- never on mem_rdata_I.
  assign stall_MEM_O = (r_state == S_IDLE) ? w_issue : !mem_ack_I;

  // -------------------------------------------------------------------------
  // Store lane steering (computed from live inputs at issue)
  // -------------------------------------------------------------------------
  logic [31:0] w_wdata;
  logic [3:0]  w_wstrb;

  always_comb begin
    w_wdata = 32'h0;
    w_wstrb = 4'b0000;
    if (MemWrite_MEM_I) begin
      case (funct3_MEM_I[1:0])
        2'b00: begin
          w_wstrb = 4'b0001 << w_off;
          w_wdata = {4{Rd_data2_MEM_I[7:0]}};
        end
        2'b01: begin
          w_wstrb = 4'b0011 << w_off;
          w_wdata = {2{Rd_data2_MEM_I[15:0]}};
        end
        default: begin
          w_wstrb = 4'b1111;
          w_wdata = Rd_data2_MEM_I;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Load extraction (uses offset/funct3 latched at issue)
  // -------------------------------------------------------------------------
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load_data;

  assign w_byte = mem_rdata_I[{r_off, 3'b000} +: 8];
  assign w_half = mem_rdata_I[{r_off[1], 4'b0000} +: 16];

  always_comb begin
    w_load_data = mem_rdata_I;
    case (r_funct3)
      F3_LB:   w_load_data = {{24{w_byte[7]}}, w_byte};
      F3_LBU:  w_load_data = {24'h0, w_byte};
      F3_LH:   w_load_data = {{16{w_half[15]}}, w_half};
      F3_LHU:  w_load_data = {16'h0, w_half};
      default: w_load_data = mem_rdata_I;
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM, bus registers and MEM/WB register
  // -------------------------------------------------------------------------
  // NOTE: all sequential state uses non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_mem_req     <= 1'b0;
      r_mem_we      <= 1'b0;
      r_mem_addr    <= 32'h0;
      r_mem_wdata   <= 32'h0;
      r_mem_wstrb   <= 4'b0000;
      r_off         <= 2'b00;
      r_funct3      <= 3'b000;
      r_wb_sel      <= 2'b00;
      r_alu         <= 32'h0;
      r_pc4         <= 32'h0;
      r_rd          <= 5'd0;
      r_regwrite    <= 1'b0;
      r_valid_wb    <= 1'b0;
      r_regwrite_wb <= 1'b0;
      r_rd_wb       <= 5'd0;
      r_wb_data     <= 32'h0;
      r_misalign_wb <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_misalign_wb <= 1'b0;
          if (w_issue) begin
            r_state     <= S_WAIT;
            r_mem_req   <= 1'b1;
            r_mem_we    <= MemWrite_MEM_I;
            r_mem_addr  <= {ALU_result_MEM_I[31:2], 2'b00};
            r_mem_wdata <= w_wdata;
            r_mem_wstrb <= w_wstrb;
            r_off       <= w_off;
            r_funct3    <= funct3_MEM_I;
            r_wb_sel    <= wb_sel_MEM_I;
            r_alu       <= ALU_result_MEM_I;
            r_pc4       <= pc_order_MEM_I;
            r_rd        <= rd_MEM_I;
            r_regwrite  <= RegWrite_MEM_I;
            // Bubble while the access is in flight.
            r_valid_wb    <= 1'b0;
            r_regwrite_wb <= 1'b0;
          end else if (w_misaligned_op) begin
            // Reported, not executed: no bus access, no register write.
            r_valid_wb    <= 1'b1;
            r_regwrite_wb <= 1'b0;
            r_rd_wb       <= rd_MEM_I;
            r_wb_data     <= ALU_result_MEM_I;
            r_misalign_wb <= 1'b1;
          end else if (valid_MEM_I) begin
            // Non-memory op; a 01 select has no load data, so it sees the
            // ALU value in that slot.
            r_valid_wb    <= 1'b1;
            r_regwrite_wb <= RegWrite_MEM_I;
            r_rd_wb       <= rd_MEM_I;
            r_wb_data     <= f_wb_mux(wb_sel_MEM_I, ALU_result_MEM_I,
                                      ALU_result_MEM_I, pc_order_MEM_I);
          end else begin
            r_valid_wb    <= 1'b0;
            r_regwrite_wb <= 1'b0;
          end
        end

        S_WAIT: begin
          if (mem_ack_I) begin
            r_state       <= S_IDLE;
            r_mem_req     <= 1'b0;
            r_mem_we      <= 1'b0;
            r_mem_wstrb   <= 4'b0000;
            r_valid_wb    <= 1'b1;
            r_regwrite_wb <= r_regwrite;
            r_rd_wb       <= r_rd;
            r_wb_data     <= f_wb_mux(r_wb_sel, r_alu, w_load_data, r_pc4);
            r_misalign_wb <= 1'b0;
          end else begin
            r_valid_wb    <= 1'b0;
            r_regwrite_wb <= 1'b0;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign mem_req_O     = r_mem_req;
  assign mem_we_O      = r_mem_we;
  assign mem_addr_O    = r_mem_addr;
  assign mem_wdata_O   = r_mem_wdata;
  assign mem_wstrb_O   = r_mem_wstrb;

  assign valid_WB_O    = r_valid_wb;
  assign RegWrite_WB_O = r_regwrite_wb;
  assign rd_WB_O       = r_rd_wb;
  assign wb_data_WB_O  = r_wb_data;
  assign misalign_WB_O = r_misalign_wb;

endmodule
